// File: rtl/cuthrough_output_arbiter.sv
// Cut-through output-port arbiter: round-robin packet lock across input channels,
// zero-latency beat forwarding from the locked channel, saturating PMU counters.
module cuthrough_output_arbiter #(
    parameter int DATA_WIDTH     = 40,
    parameter int ID_WIDTH       = 4,
    parameter int CHANNEL_NUMBER = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNEL_NUMBER-1:0]          req,
    input  logic [CHANNEL_NUMBER-1:0]          in_tvalid,
    input  logic [CHANNEL_NUMBER-1:0]          in_tlast,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
    input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0] in_tid,
    output logic [CHANNEL_NUMBER-1:0]          in_tready,
    output logic                               out_tvalid,
    output logic                               out_tlast,
    output logic [DATA_WIDTH-1:0]              out_tdata,
    output logic [ID_WIDTH-1:0]                out_tid,
    input  logic                               out_tready,
    output logic [CHANNEL_NUMBER-1:0]          grant,
    output logic [CNT_WIDTH-1:0]               pkt_count,
    output logic [CNT_WIDTH-1:0]               beat_count
);

    localparam int PTR_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [CHANNEL_NUMBER-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]          gidx_q, gidx_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]      pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0]      beat_q, beat_d;

    logic [DATA_WIDTH-1:0] data_arr [CHANNEL_NUMBER];
    logic [ID_WIDTH-1:0]   id_arr   [CHANNEL_NUMBER];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNEL_NUMBER; gi++) begin : g_chan
            assign data_arr[gi]  = in_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign id_arr[gi]    = in_tid[gi*ID_WIDTH +: ID_WIDTH];
            // grant_q is zero in IDLE, so no channel ever sees ready there
            assign in_tready[gi] = grant_q[gi] & out_tready;
        end
    endgenerate

    logic locked;
    assign locked     = (state_q == S_LOCKED);
    assign out_tvalid = locked & in_tvalid[gidx_q];
    assign out_tlast  = locked & in_tlast[gidx_q];
    assign out_tdata  = locked ? data_arr[gidx_q] : '0;
    assign out_tid    = locked ? id_arr[gidx_q] : '0;

    // Round-robin: rotate candidates so rr_ptr sits at bit 0, take the lowest set bit
    logic [CHANNEL_NUMBER-1:0]   cand;
    logic [2*CHANNEL_NUMBER-1:0] cand_sh;
    logic [CHANNEL_NUMBER-1:0]   rot;
    logic [PTR_W-1:0]            off;
    logic [PTR_W:0]              sum;
    logic [PTR_W-1:0]            win_idx;

    assign cand    = req & in_tvalid;
    assign cand_sh = {cand, cand} >> rr_ptr_q;
    assign rot     = cand_sh[CHANNEL_NUMBER-1:0];

    always_comb begin
        off = '0;
        for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
            if (rot[k]) off = PTR_W'(k);
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= (PTR_W+1)'(CHANNEL_NUMBER)) sum = sum - (PTR_W+1)'(CHANNEL_NUMBER);
        win_idx = sum[PTR_W-1:0];
    end

    logic fire;
    assign fire = out_tvalid & out_tready;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        pkt_d    = pkt_q;
        beat_d   = beat_q;
        case (state_q)
            S_IDLE: begin
                if (|cand) begin
                    state_d = S_LOCKED;
                    grant_d = CHANNEL_NUMBER'(1) << win_idx;
                    gidx_d  = win_idx;
                end
            end
            default: begin
                if (fire && out_tlast) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == PTR_W'(CHANNEL_NUMBER - 1)) ? '0 : gidx_q + PTR_W'(1);
                end
            end
        endcase
        if (fire && (beat_q != '1)) beat_d = beat_q + CNT_WIDTH'(1);
        if (fire && out_tlast && (pkt_q != '1)) pkt_d = pkt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            beat_q   <= beat_d;
        end
    end

    assign grant      = grant_q;
    assign pkt_count  = pkt_q;
    assign beat_count = beat_q;

endmodule

// File: tb/tb_cuthrough_output_arbiter.sv
// Directed bench for cuthrough_output_arbiter: vector table plus hand sequences for
// round-robin order, pointer wrap, mid-packet reset and counter saturation.
module tb_cuthrough_output_arbiter;

    localparam int DW = 40;
    localparam int IW = 4;
    localparam int CN = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [CN-1:0]   req, in_tvalid, in_tlast;
    logic [CN*DW-1:0] in_tdata;
    logic [CN*IW-1:0] in_tid;
    logic            out_tready;
    logic [CN-1:0]   in_tready, grant;
    logic            out_tvalid, out_tlast;
    logic [DW-1:0]   out_tdata;
    logic [IW-1:0]   out_tid;
    logic [15:0]     pkt_count, beat_count;

    // Narrow-counter copy sharing the same stimulus, so saturation is reachable quickly
    logic [CN-1:0]   s_in_tready, s_grant;
    logic            s_out_tvalid, s_out_tlast;
    logic [DW-1:0]   s_out_tdata;
    logic [IW-1:0]   s_out_tid;
    logic [3:0]      s_pkt_count, s_beat_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cuthrough_output_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tid(in_tid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tdata(out_tdata), .out_tid(out_tid),
        .out_tready(out_tready), .grant(grant), .pkt_count(pkt_count), .beat_count(beat_count)
    );

    cuthrough_output_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tid(in_tid), .in_tready(s_in_tready),
        .out_tvalid(s_out_tvalid), .out_tlast(s_out_tlast), .out_tdata(s_out_tdata), .out_tid(s_out_tid),
        .out_tready(out_tready), .grant(s_grant), .pkt_count(s_pkt_count), .beat_count(s_beat_count)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  req, tv, tl;
        logic        otr;
        logic [7:0]  seed;
        logic [4:0]  e_grant;
        logic        e_ov, e_ol;
        logic [4:0]  e_itr;
        int          e_ch;
        logic [15:0] e_beats, e_pkts;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [DW-1:0] chdata(input logic [7:0] seed, input int c);
        return {seed, 24'h0, 8'(c)};
    endfunction

    function automatic vec_t mkv(input logic r, input logic [4:0] rq, input logic [4:0] tv,
                                 input logic [4:0] tl, input logic otr, input logic [7:0] seed,
                                 input logic [4:0] eg, input logic eov, input logic eol,
                                 input logic [4:0] eitr, input int ech,
                                 input logic [15:0] eb, input logic [15:0] ep);
        vec_t v;
        v.rst = r; v.req = rq; v.tv = tv; v.tl = tl; v.otr = otr; v.seed = seed;
        v.e_grant = eg; v.e_ov = eov; v.e_ol = eol; v.e_itr = eitr; v.e_ch = ech;
        v.e_beats = eb; v.e_pkts = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] tv,
                         input logic [4:0] tl, input logic otr, input logic [7:0] seed);
        rst = r; req = rq; in_tvalid = tv; in_tlast = tl; out_tready = otr;
        for (int c = 0; c < CN; c++) begin
            in_tdata[c*DW +: DW] = chdata(seed, c);
            in_tid[c*IW +: IW]   = IW'(c + 1);
        end
    endtask

    // Advance one clock, drive the new inputs, then settle before sampling
    task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] tv,
                        input logic [4:0] tl, input logic otr, input logic [7:0] seed);
        @(posedge clk);
        #1;
        drive(r, rq, tv, tl, otr, seed);
        #3;
    endtask

    task automatic check_cnt(input string name, input logic [15:0] eb, input logic [15:0] ep);
        check({name, ".beats"}, 64'(beat_count), 64'(eb));
        check({name, ".pkts"}, 64'(pkt_count), 64'(ep));
        check({name, ".sat_beats"}, 64'(s_beat_count), (eb > 16'd15) ? 64'd15 : 64'(eb));
        check({name, ".sat_pkts"}, 64'(s_pkt_count), (ep > 16'd15) ? 64'd15 : 64'(ep));
    endtask

    task automatic check_out(input string name, input logic [4:0] eg, input logic eov,
                             input logic eol, input logic [4:0] eitr, input int ech,
                             input logic [7:0] seed);
        logic [DW-1:0] ed;
        logic [IW-1:0] eid;
        ed  = (ech < 0) ? '0 : chdata(seed, ech);
        eid = (ech < 0) ? '0 : IW'(ech + 1);
        check({name, ".grant"}, 64'(grant), 64'(eg));
        check({name, ".tvalid"}, 64'(out_tvalid), 64'(eov));
        check({name, ".tlast"}, 64'(out_tlast), 64'(eol));
        check({name, ".in_tready"}, 64'(in_tready), 64'(eitr));
        check({name, ".tdata"}, 64'(out_tdata), 64'(ed));
        check({name, ".tid"}, 64'(out_tid), 64'(eid));
    endtask

    logic [4:0] rr_order [4];
    logic [4:0] eg;
    int         ech;

    initial begin
        // single 3-beat packet on ch0
        vecs[0]  = mkv(0, 5'b00000, 5'b00000, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 5'b00000, -1, 0, 0);
        vecs[1]  = mkv(0, 5'b00001, 5'b00001, 5'b00000, 1, 8'h11, 5'b00000, 0, 0, 5'b00000, -1, 0, 0);
        vecs[2]  = mkv(0, 5'b00001, 5'b00001, 5'b00000, 1, 8'h11, 5'b00001, 1, 0, 5'b00001, 0, 0, 0);
        vecs[3]  = mkv(0, 5'b00001, 5'b00001, 5'b00000, 1, 8'h12, 5'b00001, 1, 0, 5'b00001, 0, 1, 0);
        vecs[4]  = mkv(0, 5'b00001, 5'b00001, 5'b00001, 1, 8'h13, 5'b00001, 1, 1, 5'b00001, 0, 2, 0);
        vecs[5]  = mkv(0, 5'b00000, 5'b00000, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 5'b00000, -1, 3, 1);
        // tvalid without req is ignored
        vecs[6]  = mkv(0, 5'b00000, 5'b00100, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 5'b00000, -1, 3, 1);
        vecs[7]  = mkv(0, 5'b00000, 5'b00100, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 5'b00000, -1, 3, 1);
        // ch2 with backpressure 1,0,0,1, then lock held while req[2] drops and ch0 requests
        vecs[8]  = mkv(0, 5'b00100, 5'b00100, 5'b00000, 1, 8'h21, 5'b00000, 0, 0, 5'b00000, -1, 3, 1);
        vecs[9]  = mkv(0, 5'b00100, 5'b00100, 5'b00000, 1, 8'h21, 5'b00100, 1, 0, 5'b00100, 2, 3, 1);
        vecs[10] = mkv(0, 5'b00100, 5'b00100, 5'b00000, 0, 8'h22, 5'b00100, 1, 0, 5'b00000, 2, 4, 1);
        vecs[11] = mkv(0, 5'b00100, 5'b00100, 5'b00000, 0, 8'h22, 5'b00100, 1, 0, 5'b00000, 2, 4, 1);
        vecs[12] = mkv(0, 5'b00100, 5'b00100, 5'b00000, 1, 8'h22, 5'b00100, 1, 0, 5'b00100, 2, 4, 1);
        vecs[13] = mkv(0, 5'b00001, 5'b00101, 5'b00100, 1, 8'h23, 5'b00100, 1, 1, 5'b00100, 2, 5, 1);
        vecs[14] = mkv(0, 5'b00001, 5'b00001, 5'b00000, 1, 8'h31, 5'b00000, 0, 0, 5'b00000, -1, 6, 2);
        vecs[15] = mkv(0, 5'b00001, 5'b00001, 5'b00001, 1, 8'h31, 5'b00001, 1, 1, 5'b00001, 0, 6, 2);
        // back-to-back requests still see one idle cycle between packets
        vecs[16] = mkv(0, 5'b00001, 5'b00001, 5'b00001, 1, 8'h32, 5'b00000, 0, 0, 5'b00000, -1, 7, 3);
        vecs[17] = mkv(0, 5'b00001, 5'b00001, 5'b00001, 1, 8'h32, 5'b00001, 1, 1, 5'b00001, 0, 7, 3);
        vecs[18] = mkv(0, 5'b00000, 5'b00000, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 5'b00000, -1, 8, 4);

        rr_order[0] = 5'b00010; rr_order[1] = 5'b01000;
        rr_order[2] = 5'b00010; rr_order[3] = 5'b01000;

        drive(1, 0, 0, 0, 1, 8'h00);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].tv, vecs[i].tl, vecs[i].otr, vecs[i].seed);
            check_out($sformatf("v%0d", i), vecs[i].e_grant, vecs[i].e_ov, vecs[i].e_ol,
                      vecs[i].e_itr, vecs[i].e_ch, vecs[i].seed);
            check_cnt($sformatf("v%0d", i), vecs[i].e_beats, vecs[i].e_pkts);
            $display("vec %0d grant=%b out_tvalid=%b beats=%0d pkts=%0d", i, grant, out_tvalid, beat_count, pkt_count);
        end

        // ch1 and ch3 with 2-beat packets alternate
        for (int cyc = 0; cyc < 12; cyc++) begin
            step(0, 5'b01010, 5'b01010, (cyc % 3 == 2) ? 5'b01010 : 5'b00000, 1, 8'(8'h40 + cyc));
            eg  = (cyc % 3 == 0) ? 5'b00000 : rr_order[cyc / 3];
            ech = (cyc % 3 == 0) ? -1 : ((eg == 5'b00010) ? 1 : 3);
            check_out($sformatf("rr%0d", cyc), eg, cyc % 3 != 0, cyc % 3 == 2, eg, ech, 8'(8'h40 + cyc));
            $display("rr cycle %0d grant=%b", cyc, grant);
        end
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h50);
        check_cnt("rr_end", 16, 8);
        check("wrap0.grant", 64'(grant), 64'b00000);

        // pointer at 4 picks ch4, then wraps to 0 and picks ch0
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h51);
        check_out("wrap1", 5'b10000, 1, 1, 5'b10000, 4, 8'h51);
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h52);
        check("wrap2.grant", 64'(grant), 64'b00000);
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h53);
        check_out("wrap3", 5'b00001, 1, 1, 5'b00001, 0, 8'h53);
        step(0, 0, 0, 0, 1, 8'h00);
        check_cnt("wrap4", 18, 10);
        $display("wrap done grant=%b beats=%0d pkts=%0d", grant, beat_count, pkt_count);

        // reset in the middle of a 4-beat ch3 packet after two beats
        step(0, 5'b01000, 5'b01000, 0, 1, 8'h60);
        check("rst0.grant", 64'(grant), 64'b00000);
        step(0, 5'b01000, 5'b01000, 0, 1, 8'h61);
        check_out("rst1", 5'b01000, 1, 0, 5'b01000, 3, 8'h61);
        step(0, 5'b01000, 5'b01000, 0, 1, 8'h62);
        check_out("rst2", 5'b01000, 1, 0, 5'b01000, 3, 8'h62);
        check_cnt("rst2", 19, 10);
        step(1, 5'b01000, 5'b01000, 0, 1, 8'h63);
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h64);
        check_out("rst4", 5'b00000, 0, 0, 5'b00000, -1, 8'h64);
        check_cnt("rst4", 0, 0);
        step(0, 5'b10001, 5'b10001, 5'b10001, 1, 8'h65);
        check_out("rst5", 5'b00001, 1, 1, 5'b00001, 0, 8'h65);
        step(0, 5'b10000, 5'b10000, 5'b10000, 1, 8'h66);
        check("rst6.grant", 64'(grant), 64'b00000);
        step(0, 5'b10000, 5'b10000, 5'b10000, 1, 8'h67);
        check_out("rst7", 5'b10000, 1, 1, 5'b10000, 4, 8'h67);
        step(0, 0, 0, 0, 1, 8'h00);
        check_cnt("rst8", 2, 2);
        $display("reset recovery grant=%b beats=%0d pkts=%0d", grant, beat_count, pkt_count);

        // 20 single-beat packets from ch4 drive the narrow counters into saturation
        for (int p = 0; p < 40; p++) begin
            step(0, 5'b10000, 5'b10000, 5'b10000, 1, 8'(p));
        end
        step(0, 0, 0, 0, 1, 8'h00);
        check_cnt("sat", 22, 22);
        check("sat.grant", 64'(grant), 64'b00000);
        $display("saturation beats=%0d pkts=%0d sat_beats=%0d sat_pkts=%0d",
                 beat_count, pkt_count, s_beat_count, s_pkt_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cuthrough_output_arbiter.md
CUTHROUGH_OUTPUT_ARBITER -- requirements
Module: cuthrough_output_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 40, meaning TDATA width per beat.
REQ-002 SHALL have parameter ID_WIDTH, default 4, meaning TID width.
REQ-003 SHALL have parameter CHANNEL_NUMBER, default 5, meaning number of router input channels competing for this output.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning width of the PMU counters.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port req, input, CHANNEL_NUMBER, meaning bit i set when channel i's routing selector targets this output.
REQ-008 SHALL have ports in_tvalid (input, CHANNEL_NUMBER), in_tlast (input, CHANNEL_NUMBER), in_tdata (input, CHANNEL_NUMBER*DATA_WIDTH), in_tid (input, CHANNEL_NUMBER*ID_WIDTH), meaning the per-channel AXI-Stream beats, channel i at slice i.
REQ-009 SHALL have port in_tready, output, CHANNEL_NUMBER, meaning per-channel ready.
REQ-010 SHALL have ports out_tvalid, out_tlast (output, 1), out_tdata (output, DATA_WIDTH), out_tid (output, ID_WIDTH), out_tready (input, 1), meaning the output AXI-Stream.
REQ-011 SHALL have port grant, output, CHANNEL_NUMBER, meaning one-hot currently locked channel, zero when idle.
REQ-012 SHALL have ports pkt_count and beat_count, output, CNT_WIDTH, meaning completed packets and transferred beats.

Function
REQ-013 SHALL implement FSM with states IDLE and LOCKED.
REQ-014 SHALL, in IDLE, compute candidates = req & in_tvalid; if nonzero, SHALL register the round-robin winner into grant and enter LOCKED on the next edge (one cycle arbitration latency).
REQ-015 SHALL pick the winner as the first candidate at or above rr_ptr, wrapping from CHANNEL_NUMBER-1 to 0.
REQ-016 SHALL, in IDLE, drive out_tvalid=0, out_tdata/out_tid/out_tlast=0, in_tready=0 on all channels.
REQ-017 SHALL, in LOCKED with grant on channel g, combinationally pass in_tvalid[g], in_tdata[g], in_tid[g], in_tlast[g] to out_* and out_tready to in_tready[g]; all other in_tready bits SHALL be 0 (cut-through, zero added latency per beat).
REQ-018 SHALL hold grant for the whole packet regardless of req changes; req SHALL be sampled only in IDLE.
REQ-019 SHALL, on a beat with out_tvalid & out_tready & out_tlast in LOCKED, return to IDLE next edge, clear grant and set rr_ptr = (g+1) mod CHANNEL_NUMBER.
REQ-020 SHALL NOT re-arbitrate in the same cycle a packet ends; minimum one IDLE cycle between packets.
REQ-021 SHALL keep beats stalled (out_tvalid=1, out_tready=0) unchanged on out_* because they are sourced from the granted channel, which must hold them per AXI-Stream.
REQ-022 SHALL increment beat_count on every out_tvalid & out_tready and pkt_count on every such beat with out_tlast; both SHALL saturate at all-ones.
REQ-023 SHALL treat a single-beat packet (header with tlast) as a complete packet: one beat, one pkt_count increment, return to IDLE.
REQ-024 SHALL ignore in_tvalid from a channel whose req is 0.
REQ-025 SHALL guarantee grant is one-hot or zero at all times.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set state IDLE, grant=0, rr_ptr=0, pkt_count=0, beat_count=0; outputs then follow REQ-016.
REQ-027 SHALL, on reset mid-packet, abandon the packet with no further beats forwarded; the partial packet SHALL NOT increment pkt_count.

Verification
REQ-028 Single request: req=00001, ch0 sends 3 beats, tlast on 3rd, out_tready=1 -> grant=00001 one cycle after tvalid, 3 beats pass unchanged, pkt_count=1, beat_count=3, grant=0 after.
REQ-029 Round-robin: ch1 and ch3 request continuously with 2-beat packets -> order ch1, ch3, ch1, ch3; rr_ptr wraps 4->0 when ch4 is granted.
REQ-030 Backpressure: out_tready toggled 1,0,0,1 mid-packet -> no beat lost or duplicated, in_tready[g] mirrors out_tready, beat_count counts only handshakes.
REQ-031 Lock: while ch2 locked, req[2] deasserted and ch0 requests -> ch2 packet completes before ch0 granted; in_tready[0]=0 throughout.
REQ-032 Reset mid-packet: rst high after beat 2 of 4 -> grant=0, pkt_count=0, beat_count=0, rr_ptr=0; next request from ch4 granted normally.
REQ-033 Saturation: preload to 16'hFFFF via 65535 single-beat packets -> further packets leave both counters at 16'hFFFF.
